switch_conditioner: RTL
=======================

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning the number of switch bits conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the stable-cycle count required before a change is accepted; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sw_raw, input, WIDTH bits: asynchronous, bouncy board switches.
REQ-006 SHALL have port sw, output, WIDTH bits: the conditioned switch bus, which drives the sw input of the mux/demux datapath top.
REQ-007 SHALL have port rise, output, WIDTH bits: one-cycle pulse per bit when that bit of sw goes 0->1.
REQ-008 SHALL have port fall, output, WIDTH bits: one-cycle pulse per bit when that bit of sw goes 1->0.
REQ-009 SHALL have port changed, output, 1 bit: one-cycle pulse equal to the OR of rise and fall.

Function
REQ-010 SHALL pass each sw_raw bit through a 2-flop synchronizer; the second flop output is s[i].
REQ-011 SHALL keep one counter per bit, ceil(log2(DEBOUNCE_CYCLES)) bits wide, that is never shared between bits.
REQ-012 SHALL, when s[i]==sw[i], clear cnt[i] to 0 and hold sw[i].
REQ-013 SHALL, when s[i]!=sw[i] and cnt[i]<DEBOUNCE_CYCLES-1, increment cnt[i].
REQ-014 SHALL, when s[i]!=sw[i] and cnt[i]==DEBOUNCE_CYCLES-1, load sw[i]<=s[i] and clear cnt[i].
REQ-015 SHALL, from REQ-012..014: a glitch shorter than DEBOUNCE_CYCLES cycles at s[i] never alters sw[i], and a bounce restarts the count from 0.
REQ-016 SHALL give latency as follows: a raw level held stable from edge k appears on sw at edge k+2+DEBOUNCE_CYCLES.
REQ-017 SHALL register rise/fall/changed so that each asserts in the same cycle sw shows its new value, and deasserts after exactly one cycle.
REQ-018 SHALL handle simultaneous changes on several bits independently; changed is a single pulse, and rise/fall show every affected bit.
REQ-019 SHALL never saturate or wrap a counter: it stops at DEBOUNCE_CYCLES-1 by REQ-014.
REQ-020 SHALL have no combinational path from sw_raw to any output.

Reset
REQ-021 SHALL, while reset=1 at a clock edge, clear synchronizer flops, counters, sw, rise, fall and changed to 0.
REQ-022 SHALL, on reset asserted mid-count, discard the pending change; after release the full 2+DEBOUNCE_CYCLES latency applies again.
REQ-023 SHALL, if sw_raw is nonzero during reset, treat it as a change from 0 after release and emit rise pulses accordingly.

Structure
REQ-024 SHALL keep default WIDTH, default DEBOUNCE_CYCLES and the synchronizer depth (2) in a shared include file for the lab board constants.
REQ-025 SHALL instantiate WIDTH copies of sub-module debounce_bit (sync, counter, state bit, edge pulses); switch_conditioner contains only the generate loop and the changed OR-reduction.

Verification (DEBOUNCE_CYCLES=4, WIDTH=10)
REQ-026 SHALL check reset: hold reset with sw_raw=10'h3FF -> sw=0 and no pulses during reset; after release, sw=10'h3FF 6 cycles later, with rise=10'h3FF and changed=1 for exactly that cycle.
REQ-027 SHALL check the glitch case: sw_raw bit0 1 for 3 cycles then 0 -> sw, rise and changed stay 0 throughout.
REQ-028 SHALL check bounce: bit1 toggles 1,0,1,0,1 (1 cycle each) then holds 1 -> sw[1] rises exactly 6 cycles after the final edge, with a single rise[1] pulse.
REQ-029 SHALL check multi-bit changes: sw_raw 0 -> 10'b0010111000 in one cycle -> sw equals it after 6 cycles, rise=10'b0010111000, one changed pulse; returning to 0 gives the matching fall pulse.
REQ-030 SHALL check reset mid-count: change bit9, assert reset after 3 cycles -> sw[9] stays 0; release with bit9 still 1 -> sw[9]=1 6 cycles after release.
REQ-031 SHALL check an exhaustive sweep: sw_raw[9:2]=0..255, each held 8 cycles -> sw tracks each value with 6-cycle latency, and fall/rise match the bitwise XOR against the previous value.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// rtl/switch_conditioner_pkg.sv - lab board switch constants shared by the conditioner
package switch_conditioner_pkg;
   localparam int SC_WIDTH          = 10;
   localparam int SC_DEBOUNCE       = 4;
   localparam int SC_SYNC_STAGES    = 2;
endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// rtl/switch_conditioner_debounce_bit.sv - one switch bit: synchronizer, debounce counter, edge pulses
module debounce_bit
   import switch_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SC_DEBOUNCE
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic sw_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SC_SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      sw_q, sw_d;
   logic                      rise_q, fall_q;
   logic                      s, load;

   assign s = sync_q[SC_SYNC_STAGES-1];

   // The counter only advances while s disagrees with sw, so it stops at CNT_MAX on the load.
   always_comb begin
      load  = 1'b0;
      cnt_d = '0;
      sw_d  = sw_q;
      if (s != sw_q) begin
         if (cnt_q == CNT_MAX) begin
            load = 1'b1;
            sw_d = s;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         sw_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SC_SYNC_STAGES-2:0], raw_i};
         cnt_q  <= cnt_d;
         sw_q   <= sw_d;
         rise_q <= load & s;
         fall_q <= load & ~s;
      end
   end

   assign sw_o   = sw_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - debounces a bus of board switches and flags their edges
module switch_conditioner
   import switch_conditioner_pkg::*;
#(
   parameter int WIDTH           = SC_WIDTH,
   parameter int DEBOUNCE_CYCLES = SC_DEBOUNCE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk    (clk),
         .reset  (reset),
         .raw_i  (sw_raw[i]),
         .sw_o   (sw[i]),
         .rise_o (rise[i]),
         .fall_o (fall[i])
      );
   end

   // Built from registered pulses only, so it lines up with rise/fall.
   assign changed = |(rise | fall);
endmodule
